// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS -> RESP, one-cycle memory access with registered read data.
// Optional macro MEM_ARBITER_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
module mem_arbiter #(
    parameter int AW = 6,
    parameter int DW = 4
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          RW0,
    input  logic          RW1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WrData0,
    input  logic [DW-1:0] WrData1,
    output logic          Ack0,
    output logic          Ack1,
    output logic [DW-1:0] RdData0,
    output logic [DW-1:0] RdData1,
    output logic          MemEnable,
    output logic          MemReadWrite,
    output logic [AW-1:0] MemAddress,
    output logic [DW-1:0] MemDataIn,
    input  logic [DW-1:0] MemDataOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          cmd_rw_q, cmd_rw_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic          cmd_id_q, cmd_id_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          grant;
    logic          grant_id;
    logic          tie_winner;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    logic last_grant_q, last_grant_d;

    assign tie_winner = ~last_grant_q;
`endif

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            cmd_rw_q    <= 1'b1;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_id_q    <= 1'b0;
            rd0_q       <= '0;
            rd1_q       <= '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_id_q    <= cmd_id_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_id_d    = cmd_id_q;
        rd0_d       = rd0_q;
        rd1_d       = rd1_q;
        grant       = 1'b0;
        grant_id    = 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (Req0 && Req1) begin
                    grant    = 1'b1;
                    grant_id = tie_winner;
                end else if (Req0 || Req1) begin
                    grant    = 1'b1;
                    grant_id = Req1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (cmd_rw_q) begin
                    if (cmd_id_q) rd1_d = MemDataOut;
                    else          rd0_d = MemDataOut;
                end
            end
            RESP: begin
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                last_grant_d = cmd_id_q;
`endif
                // Only the port not being acknowledged may be granted here.
                if (cmd_id_q ? Req0 : Req1) begin
                    grant    = 1'b1;
                    grant_id = ~cmd_id_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d     = ACCESS;
            cmd_id_d    = grant_id;
            cmd_rw_d    = grant_id ? RW1     : RW0;
            cmd_addr_d  = grant_id ? Addr1   : Addr0;
            cmd_wdata_d = grant_id ? WrData1 : WrData0;
        end
    end

    always_comb begin
        MemEnable    = (state_q == ACCESS);
        MemReadWrite = MemEnable ? cmd_rw_q    : 1'b1;
        MemAddress   = MemEnable ? cmd_addr_q  : '0;
        MemDataIn    = MemEnable ? cmd_wdata_q : '0;
        Ack0         = (state_q == RESP) && !cmd_id_q;
        Ack1         = (state_q == RESP) &&  cmd_id_q;
        RdData0      = rd0_q;
        RdData1      = rd1_q;
    end

endmodule
